// File: rtl/vector_addsub_deskew.sv
// Output realignment for the byte-skewed 256-bit vector add/sub datapath.
// Lane p arrives p cycles late; each lane is delayed 31-p cycles so all lanes meet, then results are queued in a credit-managed FIFO.
module vector_addsub_deskew #(
  parameter int FIFO_DEPTH = 4,
  parameter int LANES      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           sew_i,
  input  logic [LANES*8-1:0]   skewed_i,
  input  logic [LANES:0]       cout_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANES*8-1:0]   out_data_o,
  output logic [LANES-1:0]     out_ecarry_o,
  output logic [2:0]           out_sew_o,
  output logic                 out_sew_err_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TAGS = LANES - 1;

  typedef struct packed {
    logic [LANES*8-1:0] data;
    logic [LANES-1:0]   ecarry;
    logic [2:0]         sew;
    logic               sew_err;
  } result_t;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [LANES*8-1:0]   data_al;
  logic [LANES-1:0]     carry_al;
  logic                 unused_cout0;

  assign unused_cout0 = cout_i[0];

  // Deskew: lane p sees 31-p flops, so the last lane is taken straight from the adder.
  for (genvar p = 0; p < LANES; p++) begin : g_lane
    localparam int D = LANES - 1 - p;
    if (D == 0) begin : g_direct
      assign data_al[p*8 +: 8] = skewed_i[p*8 +: 8];
      assign carry_al[p]       = cout_i[p+1];
    end else begin : g_delay
      logic [8:0] sr [D];
      // NOTE: pure data flops carry no reset; validity travels in the tag pipe, so stale contents are never pushed.
      always_ff @(posedge clk_i) begin
        sr[0] <= {cout_i[p+1], skewed_i[p*8 +: 8]};
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
      assign {carry_al[p], data_al[p*8 +: 8]} = sr[D-1];
    end
  end

  // Tag pipe: the valid bit of an op reaches the end exactly when its lanes are aligned.
  logic [TAGS-1:0] tag_v;
  logic [2:0]      tag_sew [TAGS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_v <= '0;
      for (int i = 0; i < TAGS; i++) tag_sew[i] <= '0;
    end else begin
      tag_v      <= {tag_v[TAGS-2:0], accept};
      tag_sew[0] <= sew_i;
      for (int i = 1; i < TAGS; i++) tag_sew[i] <= tag_sew[i-1];
    end
  end

  logic [2:0]       push_sew;
  logic             push_err;
  logic [LANES-1:0] push_ecarry;
  logic [4:0]       lane_idx;

  assign push     = tag_v[TAGS-1];
  assign push_sew = tag_sew[TAGS-1];
  assign push_err = (push_sew[2:1] == 2'b11);

  // Element k's carry is the carry of its most significant byte lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    push_ecarry = '0;
    lane_idx    = '0;
    if (!push_err) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < (LANES >> push_sew)) begin
          lane_idx       = 5'(((k + 1) << push_sew) - 1);
          push_ecarry[k] = carry_al[lane_idx];
        end
      end
    end
  end

  // Result FIFO and credit accounting
  result_t        mem [FIFO_DEPTH];
  result_t        head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  inflight_nxt;
  logic [CW:0]    load_nxt;
  logic           in_ready_q;

  assign accept = in_valid_i & in_ready_q;
  assign pop    = (count != '0) & out_ready_i;

  always_comb begin
    inflight_nxt = inflight;
    count_nxt    = count;
    if (accept && !push)      inflight_nxt = inflight + 1'b1;
    else if (!accept && push) inflight_nxt = inflight - 1'b1;
    if (push && !pop)         count_nxt = count + 1'b1;
    else if (!push && pop)    count_nxt = count - 1'b1;
  end

  assign load_nxt = {1'b0, inflight_nxt} + {1'b0, count_nxt};

  // NOTE: FIFO storage has no reset; the head is masked by out_valid_o instead.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{data: data_al, ecarry: push_ecarry, sew: push_sew, sew_err: push_err};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inflight   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count      <= count_nxt;
      inflight   <= inflight_nxt;
      in_ready_q <= load_nxt < (CW+1)'(FIFO_DEPTH);
    end
  end

  assign head          = mem[rd_ptr];
  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = (count != '0);
  assign out_data_o    = out_valid_o ? head.data    : '0;
  assign out_ecarry_o  = out_valid_o ? head.ecarry  : '0;
  assign out_sew_o     = out_valid_o ? head.sew     : '0;
  assign out_sew_err_o = out_valid_o ? head.sew_err : 1'b0;

endmodule
